// File: rtl/row_sched_pkg.sv
// rtl/row_sched_pkg.sv - shared types, constants and helpers for the row request scheduler
//
// Purpose: state encoding, default row stride and the credit-window clamp used by
//          row_request_scheduler and its credit_counter.
// Ports:   none (package).

package row_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_CREDIT = 2'd1,
        ST_OFFER       = 2'd2
    } state_t;

    localparam int unsigned ROW_BYTES_DEFAULT = 2048;

    // A window of 0 would deadlock the scheduler, so it behaves as 1; anything
    // above the hardware ceiling is limited to the ceiling.
    function automatic int unsigned clamp_window(
        input int unsigned window,
        input int unsigned max_outstanding
    );
        int unsigned result;
        if (window == 0) begin
            result = 1;
        end else if (window > max_outstanding) begin
            result = max_outstanding;
        end else begin
            result = window;
        end
        return result;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - rows-in-flight counter with window compare and underflow flag
//
// Purpose: counts requests issued but not yet completed, compares against the
//          credit window, and flags completions that arrive with nothing in flight.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   i_inc                 - request handshake this cycle
//   i_dec                 - completion pulse this cycle
//   i_window              - active credit window (already clamped)
//   o_count               - registered rows in flight
//   o_has_credit          - o_count < i_window
//   o_has_credit_after    - count after this cycle's events is still < i_window
//   o_underflow_err       - registered one-cycle pulse on completion at zero

module credit_counter #(
    parameter int unsigned CW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic [CW-1:0] i_window,
    output logic [CW-1:0] o_count,
    output logic          o_has_credit,
    output logic          o_has_credit_after,
    output logic          o_underflow_err
);

    logic [CW-1:0] r_count;
    logic          r_underflow_err;
    logic [CW-1:0] w_count_next;
    logic          w_underflow;

    always_comb begin
        w_count_next = r_count;
        w_underflow  = 1'b0;
        if (i_inc && !i_dec) begin
            w_count_next = r_count + {{(CW-1){1'b0}}, 1'b1};
        end else if (i_dec && !i_inc) begin
            // Saturate at zero rather than wrapping to the top of the range.
            if (r_count == '0) begin
                w_underflow = 1'b1;
            end else begin
                w_count_next = r_count - {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count         <= '0;
            r_underflow_err <= 1'b0;
        end else begin
            r_count         <= w_count_next;
            r_underflow_err <= w_underflow;
        end
    end

    assign o_count            = r_count;
    assign o_has_credit       = (r_count < i_window);
    assign o_has_credit_after = (w_count_next < i_window);
    assign o_underflow_err    = r_underflow_err;

endmodule

// File: rtl/row_request_scheduler.sv
// rtl/row_request_scheduler.sv - issues row-fetch requests within a credit window
//
// Purpose: walks a dataset of rows, emitting one byte address per row on the
//          request stream while keeping rows in flight below the credit window
//          and honouring a minimum idle gap between non-back-to-back requests.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   start, abort                    - dataset begin / early end pulses
//   cfg_base_addr, cfg_row_count,
//   cfg_window, cfg_gap             - dataset configuration, sampled on start
//   row_complete                    - consumer pulse per finished row
//   row_requestor_idle              - high when no dataset is being issued
//   rows_requested                  - requests accepted in this dataset
//   outstanding                     - rows requested but not yet completed
//   start_rejected, credit_error    - one-cycle status pulses
//   AXIS_REQ_TDATA/TVALID/TREADY    - row request stream

module row_request_scheduler
    import row_sched_pkg::*;
#(
    parameter int unsigned ROW_BYTES       = ROW_BYTES_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = 64,
    parameter int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [63:0]   cfg_base_addr,
    input  logic [63:0]   cfg_row_count,
    input  logic [CW-1:0] cfg_window,
    input  logic [15:0]   cfg_gap,
    input  logic          row_complete,
    output logic          row_requestor_idle,
    output logic [63:0]   rows_requested,
    output logic [CW-1:0] outstanding,
    output logic          start_rejected,
    output logic          credit_error,
    output logic [63:0]   AXIS_REQ_TDATA,
    output logic          AXIS_REQ_TVALID,
    input  logic          AXIS_REQ_TREADY
);

    state_t        r_state;
    state_t        w_next_state;

    logic          r_idle;
    logic          r_tvalid;
    logic [63:0]   r_next_addr;
    logic [63:0]   r_rows_requested;
    logic [63:0]   r_row_count;
    logic [CW-1:0] r_window;
    logic [15:0]   r_gap;
    logic [15:0]   r_gap_cnt;
    logic          r_abort_pending;
    logic          r_start_rejected;

    logic          w_hs;
    logic          w_last;
    logic          w_load;
    logic          w_has_credit;
    logic          w_has_credit_after;
    logic [CW-1:0] w_count;
    logic          w_credit_err;

    assign w_hs   = r_tvalid && AXIS_REQ_TREADY;
    assign w_last = ((r_rows_requested + 64'd1) == r_row_count);

    credit_counter #(
        .CW (CW)
    ) u_credit_counter (
        .clk                (clk),
        .reset              (reset),
        .i_inc              (w_hs),
        .i_dec              (row_complete),
        .i_window           (r_window),
        .o_count            (w_count),
        .o_has_credit       (w_has_credit),
        .o_has_credit_after (w_has_credit_after),
        .o_underflow_err    (w_credit_err)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A zero-row dataset has nothing to issue and is dropped silently.
                if (start && (cfg_row_count != 64'd0)) begin
                    w_next_state = ST_WAIT_CREDIT;
                    w_load       = 1'b1;
                end
            end
            ST_WAIT_CREDIT: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if ((r_gap_cnt == 16'd0) && w_has_credit) begin
                    w_next_state = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // An offered request is never withdrawn; abort only takes
                // effect once the pending handshake has happened.
                if (w_hs) begin
                    if (w_last || r_abort_pending || abort) begin
                        w_next_state = ST_IDLE;
                    end else if ((r_gap == 16'd0) && w_has_credit_after) begin
                        w_next_state = ST_OFFER;
                    end else begin
                        w_next_state = ST_WAIT_CREDIT;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_idle           <= 1'b1;
            r_tvalid         <= 1'b0;
            r_next_addr      <= '0;
            r_rows_requested <= '0;
            r_row_count      <= '0;
            r_window         <= '0;
            r_gap            <= '0;
            r_gap_cnt        <= '0;
            r_abort_pending  <= 1'b0;
            r_start_rejected <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_idle           <= (w_next_state == ST_IDLE);
            r_tvalid         <= (w_next_state == ST_OFFER);
            r_start_rejected <= start && (r_state != ST_IDLE);

            if (w_load) begin
                r_next_addr      <= cfg_base_addr;
                r_row_count      <= cfg_row_count;
                r_window         <= CW'(clamp_window(32'(cfg_window), MAX_OUTSTANDING));
                r_gap            <= cfg_gap;
                r_rows_requested <= '0;
            end else if (w_hs) begin
                r_next_addr      <= r_next_addr + 64'(ROW_BYTES);
                r_rows_requested <= r_rows_requested + 64'd1;
            end

            // The first request of a dataset is not delayed by the gap; the
            // gap only spaces requests that fall back to WAIT_CREDIT.
            if (w_load) begin
                r_gap_cnt <= '0;
            end else if (w_hs && (w_next_state == ST_WAIT_CREDIT)) begin
                r_gap_cnt <= r_gap;
            end else if ((r_state == ST_WAIT_CREDIT) && (r_gap_cnt != 16'd0)) begin
                r_gap_cnt <= r_gap_cnt - 16'd1;
            end

            if (w_load || (w_next_state == ST_IDLE)) begin
                r_abort_pending <= 1'b0;
            end else if ((r_state == ST_OFFER) && abort) begin
                r_abort_pending <= 1'b1;
            end
        end
    end

    assign row_requestor_idle = r_idle;
    assign rows_requested     = r_rows_requested;
    assign outstanding        = w_count;
    assign start_rejected     = r_start_rejected;
    assign credit_error       = w_credit_err;
    assign AXIS_REQ_TDATA     = r_next_addr;
    assign AXIS_REQ_TVALID    = r_tvalid;

endmodule

// File: tb/tb_row_request_scheduler.sv
// tb/tb_row_request_scheduler.sv - self-checking bench for row_request_scheduler

module tb_row_request_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [63:0] cfg_base_addr;
    logic [63:0] cfg_row_count;
    logic [6:0]  cfg_window;
    logic [15:0] cfg_gap;
    logic        row_complete;
    logic        row_requestor_idle;
    logic [63:0] rows_requested;
    logic [6:0]  outstanding;
    logic        start_rejected;
    logic        credit_error;
    logic [63:0] AXIS_REQ_TDATA;
    logic        AXIS_REQ_TVALID;
    logic        AXIS_REQ_TREADY;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    row_request_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .cfg_base_addr      (cfg_base_addr),
        .cfg_row_count      (cfg_row_count),
        .cfg_window         (cfg_window),
        .cfg_gap            (cfg_gap),
        .row_complete       (row_complete),
        .row_requestor_idle (row_requestor_idle),
        .rows_requested     (rows_requested),
        .outstanding        (outstanding),
        .start_rejected     (start_rejected),
        .credit_error       (credit_error),
        .AXIS_REQ_TDATA     (AXIS_REQ_TDATA),
        .AXIS_REQ_TVALID    (AXIS_REQ_TVALID),
        .AXIS_REQ_TREADY    (AXIS_REQ_TREADY)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural model: a dataset is a list of addresses base + k*2048, the
    // credit pool is a plain count, and busy spans start to last/aborted request.
    wire         tb_hs = AXIS_REQ_TVALID && AXIS_REQ_TREADY;
    logic        m_busy, m_cerr, m_srej, m_abort_req;
    logic [63:0] m_rows, m_addr, m_total;
    logic [6:0]  m_out, m_win;
    int          hs_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_busy <= 1'b0; m_cerr <= 1'b0; m_srej <= 1'b0; m_abort_req <= 1'b0;
            m_rows <= '0; m_addr <= '0; m_total <= '0; m_out <= '0; m_win <= 7'd1;
        end else begin
            if (tb_hs) hs_cyc.push_back(cyc);
            if (tb_hs && !row_complete) m_out <= m_out + 7'd1;
            else if (row_complete && !tb_hs && m_out != 0) m_out <= m_out - 7'd1;
            m_cerr <= row_complete && !tb_hs && (m_out == 0);
            m_srej <= start && m_busy;
            if (!m_busy) begin
                if (start && cfg_row_count != 0) begin
                    m_busy <= 1'b1; m_rows <= '0; m_addr <= cfg_base_addr;
                    m_total <= cfg_row_count; m_abort_req <= 1'b0;
                    m_win <= (cfg_window == 0) ? 7'd1 : ((cfg_window > 7'd64) ? 7'd64 : cfg_window);
                end
            end else if (tb_hs) begin
                m_rows <= m_rows + 64'd1;
                m_addr <= m_addr + 64'd2048;
                if (m_rows + 64'd1 == m_total || m_abort_req || abort) m_busy <= 1'b0;
            end else if (abort) begin
                if (AXIS_REQ_TVALID) m_abort_req <= 1'b1;
                else m_busy <= 1'b0;
            end
        end
    end

    logic        p_stall = 1'b0;
    logic [63:0] p_addr = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("idle", row_requestor_idle, !m_busy);
            chk("rows_requested", rows_requested, m_rows);
            chk("outstanding", outstanding, m_out);
            chk("credit_error", credit_error, m_cerr);
            chk("start_rejected", start_rejected, m_srej);
            if (AXIS_REQ_TVALID) begin
                chk("tdata", AXIS_REQ_TDATA, m_addr);
                chk("valid_while_busy", m_busy, 1);
                chk("credit_gate", outstanding < m_win, 1);
            end
            if (p_stall) begin
                chk("hold_valid", AXIS_REQ_TVALID, 1);
                chk("hold_data", AXIS_REQ_TDATA, p_addr);
            end
        end
        p_stall <= AXIS_REQ_TVALID && !AXIS_REQ_TREADY && !reset;
        p_addr  <= AXIS_REQ_TDATA;
    end

    task automatic drain();
        int guard = 0;
        while (m_out != 0 && guard < 100) begin
            row_complete = 1'b1;
            step(1);
            guard++;
        end
        row_complete = 1'b0;
        chk("drain", m_out, 0);
    endtask

    task automatic cfg(input logic [63:0] base, input logic [63:0] cnt, input logic [6:0] win, input logic [15:0] gap);
        cfg_base_addr = base; cfg_row_count = cnt; cfg_window = win; cfg_gap = gap;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    initial begin
        bit done;
        reset = 1'b1; start = 1'b0; abort = 1'b0; row_complete = 1'b0;
        AXIS_REQ_TREADY = 1'b1;
        cfg(64'h0, 64'h0, 7'd0, 16'd0);
        step(3);
        reset = 1'b0;
        chk("rst_idle", row_requestor_idle, 1);
        chk("rst_tvalid", AXIS_REQ_TVALID, 0);
        chk("rst_tdata", AXIS_REQ_TDATA, 0);
        chk("rst_rows", rows_requested, 0);
        chk("rst_out", outstanding, 0);
        chk("rst_pulses", {start_rejected, credit_error}, 0);
        chk_en = 1'b1;

        // window-limited run
        cfg(64'h1000, 64'd4, 7'd2, 16'd0);
        pulse_start();
        chk("w_idle_low", row_requestor_idle, 0);
        chk("w_first_wait", AXIS_REQ_TVALID, 0);
        step(1); chk("w_addr0", AXIS_REQ_TDATA, 64'h1000); chk("w_v0", AXIS_REQ_TVALID, 1);
        step(1); chk("w_addr1", AXIS_REQ_TDATA, 64'h1800); chk("w_v1", AXIS_REQ_TVALID, 1);
        step(1); chk("w_stall", AXIS_REQ_TVALID, 0); chk("w_out2", outstanding, 2);
        step(3); chk("w_still_stall", AXIS_REQ_TVALID, 0);
        row_complete = 1'b1; step(1); row_complete = 1'b0;
        chk("w_out1", outstanding, 1);
        step(1); chk("w_addr2", AXIS_REQ_TDATA, 64'h2000); chk("w_v2", AXIS_REQ_TVALID, 1);
        step(1); chk("w_stall2", AXIS_REQ_TVALID, 0); chk("w_rows3", rows_requested, 3);
        row_complete = 1'b1; step(1); row_complete = 1'b0;
        step(1); chk("w_addr3", AXIS_REQ_TDATA, 64'h2800); chk("w_v3", AXIS_REQ_TVALID, 1);
        step(1); chk("w_done_idle", row_requestor_idle, 1); chk("w_rows4", rows_requested, 4);
        chk("w_out_end", outstanding, 2);
        drain();

        // backpressure
        AXIS_REQ_TREADY = 1'b0;
        cfg(64'h40000, 64'd2, 7'd4, 16'd0);
        pulse_start();
        step(1); chk("bp_v", AXIS_REQ_TVALID, 1); chk("bp_addr", AXIS_REQ_TDATA, 64'h40000);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("bp_hold_v", AXIS_REQ_TVALID, 1);
            chk("bp_hold_addr", AXIS_REQ_TDATA, 64'h40000);
            chk("bp_rows0", rows_requested, 0);
        end
        AXIS_REQ_TREADY = 1'b1;
        step(1); chk("bp_rows1", rows_requested, 1); chk("bp_addr1", AXIS_REQ_TDATA, 64'h40800);
        step(1); chk("bp_rows2", rows_requested, 2); chk("bp_idle", row_requestor_idle, 1);
        drain();

        // gap pacing
        cfg(64'h0, 64'd3, 7'd8, 16'd3);
        hs_cyc.delete();
        pulse_start();
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step(1);
            if (row_requestor_idle) done = 1'b1;
        end
        chk("gap_done", done, 1);
        chk("gap_hs_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            chk("gap_space1", hs_cyc[1] - hs_cyc[0], 5);
            chk("gap_space2", hs_cyc[2] - hs_cyc[1], 5);
        end

        // simultaneous handshake and completion, then underflow
        cfg(64'h9000, 64'd2, 7'd8, 16'd0);
        pulse_start();
        step(1); chk("sim_v", AXIS_REQ_TVALID, 1);
        row_complete = 1'b1; step(1); row_complete = 1'b0;
        chk("sim_out", outstanding, 3); chk("sim_addr", AXIS_REQ_TDATA, 64'h9800);
        step(1); chk("sim_out4", outstanding, 4); chk("sim_idle", row_requestor_idle, 1);
        drain();
        row_complete = 1'b1; step(1); row_complete = 1'b0;
        chk("uf_err", credit_error, 1); chk("uf_out", outstanding, 0);
        step(1); chk("uf_err_pulse", credit_error, 0);

        // abort during OFFER under backpressure, start while busy
        AXIS_REQ_TREADY = 1'b0;
        cfg(64'h100000, 64'd10, 7'd8, 16'd0);
        pulse_start();
        step(1); chk("ab_v", AXIS_REQ_TVALID, 1);
        abort = 1'b1; step(1); abort = 1'b0;
        chk("ab_hold", AXIS_REQ_TVALID, 1); chk("ab_busy", row_requestor_idle, 0);
        cfg(64'hDEAD0000, 64'd3, 7'd1, 16'd0);
        pulse_start();
        chk("sr_pulse", start_rejected, 1); chk("sr_addr", AXIS_REQ_TDATA, 64'h100000);
        step(1); chk("sr_pulse_end", start_rejected, 0);
        AXIS_REQ_TREADY = 1'b1;
        step(1); chk("ab_idle", row_requestor_idle, 1); chk("ab_rows", rows_requested, 1);
        chk("ab_v_low", AXIS_REQ_TVALID, 0);
        step(2); chk("ab_quiet", AXIS_REQ_TVALID, 0);

        // abort while waiting on the gap
        cfg(64'h200000, 64'd5, 7'd8, 16'd4);
        pulse_start();
        step(1); chk("abw_v", AXIS_REQ_TVALID, 1);
        step(1); chk("abw_wait", AXIS_REQ_TVALID, 0);
        abort = 1'b1; step(1); abort = 1'b0;
        chk("abw_idle", row_requestor_idle, 1);
        step(6); chk("abw_quiet", AXIS_REQ_TVALID, 0); chk("abw_rows", rows_requested, 1);
        drain();

        // window 0 behaves as 1
        cfg(64'h300000, 64'd3, 7'd0, 16'd0);
        pulse_start();
        step(1); chk("w0_v", AXIS_REQ_TVALID, 1);
        step(1); chk("w0_stall", AXIS_REQ_TVALID, 0); chk("w0_out", outstanding, 1);
        step(2); chk("w0_still", AXIS_REQ_TVALID, 0);
        row_complete = 1'b1; step(1); row_complete = 1'b0;
        step(1); chk("w0_addr1", AXIS_REQ_TDATA, 64'h300800); chk("w0_v1", AXIS_REQ_TVALID, 1);
        step(1); row_complete = 1'b1; step(1); row_complete = 1'b0;
        step(1); chk("w0_addr2", AXIS_REQ_TDATA, 64'h301000);
        step(1); chk("w0_idle", row_requestor_idle, 1); chk("w0_rows", rows_requested, 3);
        drain();

        // window above the ceiling clamps to 64
        cfg(64'h0, 64'd70, 7'd100, 16'd0);
        pulse_start();
        step(80);
        chk("cl_out", outstanding, 64); chk("cl_rows", rows_requested, 64);
        chk("cl_v", AXIS_REQ_TVALID, 0);
        abort = 1'b1; step(1); abort = 1'b0;
        chk("cl_idle", row_requestor_idle, 1);
        drain();

        // zero-count start
        cfg(64'h5000, 64'd0, 7'd4, 16'd0);
        pulse_start();
        chk("z_idle", row_requestor_idle, 1); chk("z_srej", start_rejected, 0);
        step(3); chk("z_v", AXIS_REQ_TVALID, 0); chk("z_idle2", row_requestor_idle, 1);

        // reset mid-run
        cfg(64'h400000, 64'd20, 7'd8, 16'd0);
        pulse_start();
        step(3); chk("rr_running", AXIS_REQ_TVALID, 1);
        reset = 1'b1; step(1); reset = 1'b0;
        chk("rr_v", AXIS_REQ_TVALID, 0); chk("rr_tdata", AXIS_REQ_TDATA, 0);
        chk("rr_rows", rows_requested, 0); chk("rr_out", outstanding, 0);
        chk("rr_idle", row_requestor_idle, 1);
        step(2); chk("rr_quiet", AXIS_REQ_TVALID, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog expired actual=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/row_request_scheduler.md
# row_request_scheduler

Issues row-fetch requests for a dataset and keeps the number of rows in flight within a credit window. It owns the `row_requestor_idle` signal that the stream consumer watches. Each accepted request returns one credit when the consumer pulses `row_complete`. The block sits between the host-side configuration registers and the row-request AXI stream.

## Interface

**Parameters**

- `ROW_BYTES`, 2048: byte stride between consecutive row addresses.
- `MAX_OUTSTANDING`, 64: hardware ceiling on rows in flight.
- `CW`, `$clog2(MAX_OUTSTANDING+1)`: width of the outstanding counter.

**Ports**

- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a dataset.
- `abort` in 1: one-cycle pulse that ends the dataset early.
- `cfg_base_addr` in 64: address of row 0, sampled on `start`.
- `cfg_row_count` in 64: rows to request, sampled on `start`.
- `cfg_window` in CW: credit window, sampled on `start`.
  - 0 is treated as 1.
  - Values above MAX_OUTSTANDING are clamped to MAX_OUTSTANDING.
- `cfg_gap` in 16: minimum idle cycles between requests, sampled on `start`.
- `row_complete` in 1: one-cycle pulse from the consumer per finished row.
- `row_requestor_idle` out 1: high when no dataset is being issued.
- `rows_requested` out 64: requests accepted in the current dataset.
- `outstanding` out CW: rows requested but not yet completed.
- `start_rejected` out 1: pulses when `start` arrives while busy.
- `credit_error` out 1: pulses when `row_complete` arrives with `outstanding`==0.
- `AXIS_REQ_TDATA` out 64: byte address of the requested row.
- `AXIS_REQ_TVALID` out 1: request valid.
- `AXIS_REQ_TREADY` in 1: downstream accepts the request.

## Operation

- **States:** IDLE, WAIT_CREDIT, OFFER.
- **IDLE:**
  - `row_requestor_idle`=1.
  - On `start` with `cfg_row_count`≠0: latch config, clear `rows_requested`, set next-address = base, go to WAIT_CREDIT.
  - On `start` with `cfg_row_count`==0: ignored, stay in IDLE with no pulse.
- **WAIT_CREDIT:**
  - TVALID=0.
  - Go to OFFER when gap counter==0 and `outstanding` < window. The comparison uses the already-updated `outstanding` (registered value).
- **OFFER:**
  - TVALID=1 and TDATA=next-address. Both stay stable until TREADY (AXIS rule; never withdrawn).
  - On handshake: `rows_requested`+1, next-address += ROW_BYTES (64-bit wrap).
    - If this was the last row: go to IDLE.
    - Else if gap==0 and a credit is still free after this handshake: stay in OFFER, so back-to-back requests proceed with the new address.
    - Else: go to WAIT_CREDIT with the gap counter loaded from `cfg_gap`.
- **Credits:**
  - Request handshake alone: `outstanding`+1.
  - `row_complete` alone: `outstanding`−1.
  - Both in the same cycle: unchanged.
  - `row_complete` at 0: saturates at 0 and pulses `credit_error`.
  - Credits are tracked in every state, including IDLE, because completions trail the last request.
- **Abort:**
  - In WAIT_CREDIT: go to IDLE next cycle.
  - In OFFER: hold until the pending handshake completes, then go to IDLE. That request counts.
  - `outstanding` is not cleared.
- **Start while busy:** ignored, pulses `start_rejected`, latched config unchanged.

## Timing

- **Reset values:**
  - IDLE, `row_requestor_idle`=1, TVALID=0, TDATA=0.
  - `rows_requested`=0, `outstanding`=0.
  - `start_rejected`=0, `credit_error`=0.
- **Start to first request:** `start` at cycle N puts `row_requestor_idle` low at N+1 (state WAIT_CREDIT). First TVALID is at N+2 when a credit is free.
- **Request spacing:** a handshake at cycle M followed by WAIT_CREDIT gives the next TVALID no earlier than M+2+`cfg_gap`. With gap 0 and free credit, throughput is one request per cycle.
- **Back to idle:** `row_requestor_idle` rises the cycle after the final handshake or the abort exit.
- **Output registers:** all outputs are registered. Pulses last exactly one cycle.
- **Reset mid-dataset:** drops TVALID immediately and returns every output to its reset value.

## Structure

- Package `row_sched_pkg`:
  - state enum.
  - `ROW_BYTES_DEFAULT`.
  - window clamp function.
- Sub-module `credit_counter`:
  - inputs: inc, dec, window.
  - outputs: count, `has_credit`, saturating-underflow error.
  - instantiated once.

## Test plan

- **Window-limited run:**
  - Stimulus: base=0x1000, count=4, window=2, gap=0, TREADY=1, no completions.
  - Response: addresses 0x1000 and 0x1800 in consecutive cycles, then TVALID stays low. `outstanding`=2.
  - Then one `row_complete` → 0x2000 issued. A second `row_complete` → 0x2800 issued, then idle rises.
- **Backpressure:**
  - Stimulus: TREADY held low 5 cycles during OFFER.
  - Response: TVALID and TDATA stable throughout. `rows_requested` increments only on the accepting cycle.
- **Gap pacing:**
  - Stimulus: count=3, window=8, gap=3.
  - Response: handshakes at cycles M, M+5, M+10.
- **Simultaneous events and credit underflow:**
  - Stimulus: handshake and `row_complete` in the same cycle.
  - Response: `outstanding` unchanged.
  - Stimulus: `row_complete` with `outstanding`=0.
  - Response: `credit_error` pulses once, count stays 0.
- **Abort and start while busy:**
  - Stimulus: abort during OFFER with TREADY=0, then TREADY=1.
  - Response: one final handshake, then idle.
  - Stimulus: `start` while busy.
  - Response: `start_rejected` pulses, addresses continue unchanged.
- **Zero-count start and reset mid-run:**
  - Stimulus: `start` with count=0.
  - Response: idle stays high, no TVALID.
  - Stimulus: `reset` mid-run.
  - Response: TVALID=0, counters 0 next cycle.
